// File: rtl/block_memory_responder_if.sv
// -----------------------------------------------------------------------------
// cache_parameters: word/block geometry and the block-granular memory-port
// request/response types shared by the cache and its memory responder.
//
// block_memory_responder_if: bundles the memory port.
//   mem_req : memory_request_t  (cs, rw[1=write], addr, data block)  master -> slave
//   mem_res : memory_response_t (ack, data block)                    slave  -> master
//   busy    : responder has an operation in flight                   slave  -> master
// -----------------------------------------------------------------------------
package cache_parameters;
  localparam int WORD_WIDTH   = 32;
  localparam int BLOCK_SIZE   = 4;   // words per block
  localparam int ADDR_WIDTH   = 32;  // byte address
  localparam int OFFSET_WIDTH = 4;   // byte offset within a block (4 words x 4 bytes)
  localparam int ADDR_MSB     = ADDR_WIDTH - 1;

  // Word i of a block is data[i].
  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef struct packed {
    logic              cs;
    logic              rw;
    logic [ADDR_MSB:0] addr;
    block_t            data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;
endpackage

interface block_memory_responder_if;
  import cache_parameters::*;

  memory_request_t  mem_req;
  memory_response_t mem_res;
  logic             busy;

  modport master (output mem_req, input  mem_res, input  busy);
  modport slave  (input  mem_req, output mem_res, output busy);
endinterface

// File: rtl/block_memory_responder.sv
// -----------------------------------------------------------------------------
// block_memory_responder
//   Block-granular main-memory model for the cache's memory port. Accepts one
//   block read or write at a time, waits a programmable latency, then pulses
//   ack for one cycle. Reads return the whole block on the ack cycle; writes
//   commit to the array on the edge leaving the ack cycle.
//
// Ports:
//   clk     : single clock, rising edge
//   rst     : asynchronous, active-low reset
//   mem_if  : slave side of block_memory_responder_if (mem_req in,
//             mem_res / busy out, all outputs registered)
// -----------------------------------------------------------------------------
module block_memory_responder
  import cache_parameters::*;
#(
  parameter int DEPTH_BLOCKS  = 256,  // power of two
  parameter int READ_LATENCY  = 4,    // >= 1
  parameter int WRITE_LATENCY = 4     // >= 1
) (
  input  logic                      clk,
  input  logic                      rst,
  block_memory_responder_if.slave   mem_if
);

  localparam int IDX_W   = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              rw_q,    rw_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  block_t            wdata_q, wdata_d;
  block_t            rdata_q, rdata_d;
  logic              ack_q,   ack_d;
  logic              busy_q,  busy_d;
  logic              mem_we;

  block_t            mem [DEPTH_BLOCKS];

  // Offset bits and address bits above the index are deliberately ignored,
  // so addresses alias modulo the depth.
  logic [IDX_W-1:0]  req_idx;
  logic [CNT_W-1:0]  req_load;
  logic              unused_addr;

  assign req_idx     = mem_if.mem_req.addr[OFFSET_WIDTH +: IDX_W];
  assign req_load    = mem_if.mem_req.rw ? WRITE_LOAD : READ_LOAD;
  assign unused_addr = ^mem_if.mem_req.addr;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. mem_req is only looked at in IDLE, so a drop or change
  // of cs mid-operation cannot abort or restart the transaction.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (mem_if.mem_req.cs) begin
          rw_d    = mem_if.mem_req.rw;
          idx_d   = req_idx;
          wdata_d = mem_if.mem_req.data;
          cnt_d   = req_load;
          // A latency of 1 has no wait cycles: ack follows acceptance directly.
          state_d = (req_load == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // The decrement that reaches zero is the edge that enters RESP.
        if (cnt_q <= CNT_ONE) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. ack/busy are computed from the next state and registered,
  // so mem_res.ack has no combinational path from mem_req (the initiator drops
  // cs combinationally on ack).
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d   = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
    rdata_d = rdata_q;
    // Read data is captured on the edge entering RESP and then held; write
    // responses leave it untouched.
    if (state_d == S_RESP && state_q != S_RESP && !rw_d) begin
      rdata_d = mem[idx_d];
    end
    // The write commits on the edge leaving RESP; a reset before then forces
    // the FSM out of RESP and the write is dropped.
    mem_we = (state_q == S_RESP) && rw_q;
  end

  // ---------------------------------------------------------------------------
  // Block array
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is intentionally not reset; its contents are
  // undefined until written, exactly like a real memory.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign mem_if.mem_res = '{ack: ack_q, data: rdata_q};
  assign mem_if.busy    = busy_q;

endmodule

// File: doc/block_memory_responder.md
# block_memory_responder

Behavioural-synthesisable main-memory responder serving the cache's block-granular memory port. It is the far end of the `memory_request_t` / `memory_response_t` interface. It accepts one block read or write at a time, waits a programmable latency, then pulses `ack`. On reads, it returns the whole block on the `ack` cycle. It backs the cache in integration and is the reference target for cache verification.

## Interface
Parameters:
- `DEPTH_BLOCKS`, default 256: number of blocks stored; power of two.
- `READ_LATENCY`, default 4: cycles from request acceptance to read `ack`; ≥1.
- `WRITE_LATENCY`, default 4: cycles from request acceptance to write `ack`; ≥1.
- Word width, block size and address fields come from `cache_parameters`: `WORD_WIDTH`, `BLOCK_SIZE`, `OFFSET_WIDTH`, address field MSB/LSB constants.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`  in  `memory_request_t`  request fields: `cs`, `rw` (1 = write), `addr`, `data[BLOCK_SIZE]`.
- `mem_res`  out  `memory_response_t`  response fields: `ack`, `data[BLOCK_SIZE]`.
- `busy`  out  1  high from acceptance through the `ack` cycle inclusive.

## Operation
- Storage is `DEPTH_BLOCKS` × `BLOCK_SIZE` words.
- Block index = `addr[OFFSET_WIDTH +: log2(DEPTH_BLOCKS)]`. Higher address bits are ignored, so addresses wrap modulo the depth. Offset bits are ignored.
- FSM states:
  - IDLE → WAIT when `cs`=1. The responder latches `rw`, the block index and `data`, and loads the counter with latency−1.
  - WAIT decrements the counter each cycle. WAIT → RESP when the counter reaches 0.
  - RESP → IDLE always.
- Write: the array is updated with the latched block on the clock edge leaving RESP.
- Read: `mem_res.data` is loaded from the array on the edge entering RESP. It then holds until the next read response. Write responses do not alter `mem_res.data`.
- `mem_res.ack` = 1 exactly when the FSM is in RESP. It is registered only and has no combinational path from `mem_req`. This is required because the initiator drops `cs` combinationally on `ack`.
- `mem_req` is ignored in WAIT and RESP. A change or drop of `cs` mid-operation does not abort the transaction.
- The array has no reset. Contents are X until written, unless preloaded by the testbench via hierarchical access.
- Reset (`rst`=0, at any time, including mid-transaction):
  - FSM → IDLE, counter → 0.
  - `mem_res.ack` → 0, `mem_res.data` → all zeros, `busy` → 0.
  - An in-flight write is dropped and the array is not updated.

## Timing
- The request is sampled at edge T with the FSM in IDLE and `cs`=1.
- `ack` is high during the cycle following edge T+L−1, where L is the applicable latency. It lasts exactly one cycle.
- With L=1, `ack` is high in the cycle immediately after acceptance.
- Back-to-back requests: IDLE is re-entered the cycle after `ack`. A request presented there is accepted at that edge.
- This matches the initiator's pattern of a write-back `ack` followed by an allocate read in the next cycle. Minimum spacing between acceptances is L+1 cycles.
- Read-after-write to the same block is coherent. The write commits on the edge leaving RESP, before the next acceptance can occur.
- `cs` held high during the `ack` cycle is not a new request. The next request is sampled only in IDLE.
- `busy` = (state ≠ IDLE), registered.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release with `cs`=0 → `ack`=0, `busy`=0, `mem_res.data`=0 for 10 cycles.
- Write then read: write block `{1,2,3,4}` to addr 0x40, then read 0x40 (READ_LATENCY=4, WRITE_LATENCY=4) → each `ack` is a single cycle, 4 cycles after acceptance. Read data = `{1,2,3,4}`.
- Write-back then allocate: `ack` the write to 0x80, then present a read of 0x100 the next cycle → the read is accepted immediately. Read-data `ack` arrives 4 cycles later. The stored 0x80 block matches on a subsequent read.
- Wrap: with DEPTH_BLOCKS=256, write `{A,B,C,D}` to block 5, then read block 5+256 → returns `{A,B,C,D}`.
- Mid-operation reset: assert `rst` 2 cycles into a write to 0x20 → `ack` never pulses. A later read of 0x20 returns the prior contents.
- Latency 1: set READ_LATENCY=1 and hold `cs` high continuously → acceptance, `ack`, accept, `ack` repeats every 2 cycles with no missed or duplicate `ack`.
